instr_aligner: RTL and testbench

Front-end instruction aligner that produces the aligned-instruction stream consumed by the decoder. It accepts 32-bit fetch words tagged with fetch error and prediction information and holds up to one leftover halfword. It emits one RVI or RVC instruction per cycle through a registered valid/ready output stage, together with its fetch error, alignment error and prediction flag. It sits between the fetch buffer and the ID-stage decoder.

---
 rtl/instr_aligner_pkg.sv | 45 ++++
 rtl/instr_aligner_select.sv | 89 ++++++++
 rtl/instr_aligner.sv | 81 ++++++++
 tb/tb_instr_aligner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/instr_aligner_pkg.sv
// Shared types for the instruction aligner: fetch error codes, halfword
// buffer / output records and the alignment decision encoding.
package instr_aligner_pkg;

    localparam logic [2:0] FETCH_VALID   = 3'b000;
    localparam logic [2:0] FETCH_BUSERR  = 3'b001;
    localparam logic [2:0] FETCH_UCE     = 3'b010;
    localparam logic [2:0] FETCH_CE      = 3'b011;
    localparam logic [2:0] FETCH_MISPRED = 3'b100;

    localparam logic [1:0] RVI_LOW = 2'b11;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  err;
        logic        pred;
    } half_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  err;
        logic        align;
        logic        pred;
    } instr_t;

    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_START_HI,
        SEL_RVI,
        SEL_RVC_LO,
        SEL_BUF_RVC,
        SEL_SPLIT,
        SEL_ALIGN
    } sel_e;

    function automatic logic is_rvi(input logic [15:0] h);
        return h[1:0] == RVI_LOW;
    endfunction

    // An instruction spanning two sources reports the earliest fault.
    function automatic logic [2:0] merge_err(input logic [2:0] first, input logic [2:0] second);
        return (first != FETCH_VALID) ? first : second;
    endfunction

endpackage

// File: rtl/instr_aligner_select.sv
// Combinational alignment decision: what to emit, whether the fetch word is
// consumed and the next state of the leftover-halfword buffer.
module instr_aligner_select
    import instr_aligner_pkg::*;
(
    input  logic        h_valid,
    input  half_t       h_cur,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    input  logic [2:0]  fetch_error,
    input  logic        fetch_start,
    input  logic        fetch_half,
    input  logic        fetch_pred,
    output logic        emit,
    output instr_t      instr,
    output logic        consume,
    output logic        h_valid_nxt,
    output half_t       h_nxt
);
    sel_e        sel;
    logic [15:0] lo;
    logic [15:0] hi;

    assign lo = fetch_data[15:0];
    assign hi = fetch_data[31:16];

    always_comb begin
        sel = SEL_IDLE;
        if (!h_valid) begin
            if (fetch_valid) begin
                if (fetch_start && fetch_half) sel = SEL_START_HI;
                else if (is_rvi(lo))           sel = SEL_RVI;
                else                           sel = SEL_RVC_LO;
            end
        end else if (!is_rvi(h_cur.data)) begin
            sel = SEL_BUF_RVC;
        end else if (h_cur.pred) begin
            // a predicted-taken incomplete RVI can never be completed
            sel = SEL_ALIGN;
        end else if (fetch_valid) begin
            sel = fetch_start ? SEL_ALIGN : SEL_SPLIT;
        end
    end

    always_comb begin
        emit        = 1'b0;
        instr       = '0;
        consume     = 1'b0;
        h_valid_nxt = h_valid;
        h_nxt       = h_cur;
        case (sel)
            SEL_START_HI: begin
                consume     = 1'b1;
                h_valid_nxt = 1'b1;
                h_nxt       = '{hi, fetch_error, fetch_pred};
            end
            SEL_RVI: begin
                emit    = 1'b1;
                instr   = '{fetch_data, fetch_error, 1'b0, fetch_pred};
                consume = 1'b1;
            end
            SEL_RVC_LO: begin
                emit        = 1'b1;
                instr       = '{{16'h0, lo}, fetch_error, 1'b0, 1'b0};
                consume     = 1'b1;
                h_valid_nxt = 1'b1;
                h_nxt       = '{hi, fetch_error, fetch_pred};
            end
            SEL_BUF_RVC: begin
                emit        = 1'b1;
                instr       = '{{16'h0, h_cur.data}, h_cur.err, 1'b0, h_cur.pred};
                h_valid_nxt = 1'b0;
            end
            SEL_SPLIT: begin
                emit    = 1'b1;
                instr   = '{{lo, h_cur.data}, merge_err(h_cur.err, fetch_error), 1'b0, 1'b0};
                consume = 1'b1;
                h_nxt   = '{hi, fetch_error, fetch_pred};
            end
            SEL_ALIGN: begin
                emit        = 1'b1;
                instr       = '{{16'h0, h_cur.data}, h_cur.err, 1'b1, h_cur.pred};
                h_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_aligner.sv
// Instruction aligner: turns 32-bit fetch words into one RVI/RVC instruction
// per cycle through a registered valid/ready stage toward the decoder.
module instr_aligner
    import instr_aligner_pkg::*;
(
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic        s_fetch_valid_i,
    input  logic [31:0] s_fetch_data_i,
    input  logic [2:0]  s_fetch_error_i,
    input  logic        s_fetch_start_i,
    input  logic        s_fetch_half_i,
    input  logic        s_fetch_pred_i,
    output logic        s_fetch_ready_o,
    output logic [31:0] s_instr_o,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output logic [2:0]  s_fetch_error_o,
    output logic        s_align_error_o,
    output logic        s_prediction_o
);
    logic   h_valid;
    half_t  h_q;
    logic   out_v;
    instr_t out_q;

    logic   sel_emit;
    instr_t sel_instr;
    logic   sel_consume;
    logic   sel_h_valid;
    half_t  sel_h;

    logic   load;
    logic   act;

    instr_aligner_select u_select (
        .h_valid     (h_valid),
        .h_cur       (h_q),
        .fetch_valid (s_fetch_valid_i),
        .fetch_data  (s_fetch_data_i),
        .fetch_error (s_fetch_error_i),
        .fetch_start (s_fetch_start_i),
        .fetch_half  (s_fetch_half_i),
        .fetch_pred  (s_fetch_pred_i),
        .emit        (sel_emit),
        .instr       (sel_instr),
        .consume     (sel_consume),
        .h_valid_nxt (sel_h_valid),
        .h_nxt       (sel_h)
    );

    // The output stage advances only when empty or drained by the decoder.
    assign load            = ~out_v | s_ready_i;
    assign act             = load & ~s_flush_i;
    assign s_fetch_ready_o = act & sel_consume;

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            h_valid <= 1'b0;
            h_q     <= '{16'h0, FETCH_VALID, 1'b0};
            out_v   <= 1'b0;
            out_q   <= '{32'h0, FETCH_VALID, 1'b0, 1'b0};
        end else if (s_flush_i) begin
            h_valid <= 1'b0;
            out_v   <= 1'b0;
        end else if (load) begin
            h_valid <= sel_h_valid;
            h_q     <= sel_h;
            out_v   <= sel_emit;
            if (sel_emit) out_q <= sel_instr;
        end
    end

    assign s_valid_o       = out_v;
    assign s_instr_o       = out_q.instr;
    assign s_fetch_error_o = out_q.err;
    assign s_align_error_o = out_q.align;
    assign s_prediction_o  = out_q.pred;

endmodule

// File: tb/tb_instr_aligner.sv
// Directed self-checking bench for instr_aligner.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fv;
    logic [31:0] fd;
    logic [2:0]  fe;
    logic        fst;
    logic        fhalf;
    logic        fpred;
    logic        fready;
    logic [31:0] instr;
    logic        valid;
    logic        ready;
    logic [2:0]  ferr;
    logic        aerr;
    logic        pred;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_aligner dut (
        .s_clk_i         (clk),
        .s_resetn_i      (rst_n),
        .s_flush_i       (flush),
        .s_fetch_valid_i (fv),
        .s_fetch_data_i  (fd),
        .s_fetch_error_i (fe),
        .s_fetch_start_i (fst),
        .s_fetch_half_i  (fhalf),
        .s_fetch_pred_i  (fpred),
        .s_fetch_ready_o (fready),
        .s_instr_o       (instr),
        .s_valid_o       (valid),
        .s_ready_i       (ready),
        .s_fetch_error_o (ferr),
        .s_align_error_o (aerr),
        .s_prediction_o  (pred)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".vld"},   {31'h0, valid}, 32'h0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".ferr"},  {29'h0, ferr}, 32'h0);
        chk({tag, ".aerr"},  {31'h0, aerr}, 32'h0);
        chk({tag, ".pred"},  {31'h0, pred}, 32'h0);
    endtask

    // Drive one fetch slot, check the combinational consume, clock, check outputs.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic [2:0] e, input logic st, input logic hf, input logic pr,
                        input logic x_rdy, input logic x_v, input logic [31:0] x_i,
                        input logic [2:0] x_e, input logic x_a, input logic x_p);
        fv = v; fd = d; fe = e; fst = st; fhalf = hf; fpred = pr;
        #1;
        chk({tag, ".rdy"}, {31'h0, fready}, {31'h0, x_rdy});
        @(posedge clk); #1;
        chk({tag, ".vld"}, {31'h0, valid}, {31'h0, x_v});
        if (x_v) begin
            chk({tag, ".instr"}, instr, x_i);
            chk({tag, ".ferr"},  {29'h0, ferr}, {29'h0, x_e});
            chk({tag, ".aerr"},  {31'h0, aerr}, {31'h0, x_a});
            chk({tag, ".pred"},  {31'h0, pred}, {31'h0, x_p});
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready = 1'b1;
        fv = 1'b0; fd = '0; fe = '0; fst = 1'b0; fhalf = 1'b0; fpred = 1'b0;
        #1;
        chk_reset("rst0");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // two RVC in one word: C then D, consumed only in the first cycle
        step("c1", 1, 32'h4505_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        step("d1", 1, 32'h0513_4501, 0, 0, 0, 0, 0, 1, 32'h0000_4505, 0, 0, 0);
        // split RVI 0x00A00513
        step("c2", 1, 32'h0513_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        step("e1", 1, 32'h4585_00A0, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 0, 0, 0);
        step("d2", 0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 0, 0, 0);
        // error only on the second word
        step("c3", 1, 32'h0513_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        step("e2", 1, 32'h4585_00A0, 2, 0, 0, 0, 1, 1, 32'h00A0_0513, 2, 0, 0);
        step("d3", 0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 2, 0, 0);
        // first-halfword error wins
        step("c4", 1, 32'h0513_4501, 1, 0, 0, 0, 1, 1, 32'h0000_4501, 1, 0, 0);
        step("e3", 1, 32'h4585_00A0, 2, 0, 0, 0, 1, 1, 32'h00A0_0513, 1, 0, 0);
        step("d4", 0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 2, 0, 0);
        // incomplete RVI hit by a redirect
        step("c5", 1, 32'h0513_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        step("f1", 1, 32'h0013_0013, 0, 1, 0, 0, 0, 1, 32'h0000_0513, 0, 1, 0);
        step("b1", 1, 32'h0013_0013, 0, 1, 0, 0, 1, 1, 32'h0013_0013, 0, 0, 0);
        // prediction on an incomplete RVI
        step("c6", 1, 32'h0513_4501, 0, 0, 0, 1, 1, 1, 32'h0000_4501, 0, 0, 0);
        step("g1", 1, 32'h4585_00A0, 0, 0, 0, 0, 0, 1, 32'h0000_0513, 0, 1, 1);
        step("c7", 1, 32'h4585_00A0, 0, 0, 0, 0, 1, 1, 32'h0000_00A0, 0, 0, 0);
        step("d5", 0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 0, 0, 0);
        // redirect into the upper halfword
        step("a1", 1, 32'h4585_1234, 3, 1, 1, 1, 1, 0, 32'h0,         0, 0, 0);
        step("d6", 0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 3, 0, 1);
        step("b2", 1, 32'h00A0_0513, 0, 0, 0, 1, 1, 1, 32'h00A0_0513, 0, 0, 1);
        step("idle", 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0);

        // stall then flush
        step("c8", 1, 32'h0513_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("hold", 1, 32'h4585_00A0, 0, 0, 0, 0, 0, 1, 32'h0000_4501, 0, 0, 0);
        flush = 1'b1; ready = 1'b1;
        step("flush", 1, 32'h4585_00A0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        flush = 1'b0;
        step("post", 1, 32'h4585_00A0, 0, 0, 0, 0, 1, 1, 32'h0000_00A0, 0, 0, 0);
        step("d7",   0, 32'h0,         0, 0, 0, 0, 0, 1, 32'h0000_4585, 0, 0, 0);

        // asynchronous reset with a halfword held
        step("c9", 1, 32'h0513_4501, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rb", 1, 32'h00A0_0513, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
